// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package seven_seg_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {IDLE, DEAD, DRIVE} state_e;

  function automatic int cnt_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction
endpackage

// File: rtl/seven_seg_lzb.sv
// Leading-zero blank mask: digit i>=1 is dark when it and every higher nibble are zero.
module seven_seg_lzb import seven_seg_pkg::*; #(
  parameter int NUM_DIGITS = 4
) (
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]          mask
);
  logic zero_above;

  always_comb begin
    mask       = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS-1; i >= 0; i--) begin
      zero_above = zero_above & (digits[i*NIBBLE_W +: NIBBLE_W] == '0);
      mask[i]    = zero_above && (i != 0);
    end
  end
endmodule

// File: rtl/seven_seg_scanner.sv
// Round-robin common-anode scan controller with frame-aligned double-buffered digits.
// Optional leading-zero blanking is built when LEADING_ZERO_BLANK_EN is defined.
module seven_seg_scanner import seven_seg_pkg::*; #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic                           load,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]          blank_mask,
  output logic [NIBBLE_W-1:0]            digit_code,
  output logic [NUM_DIGITS-1:0]          an_n,
  output logic                           load_ack,
  output logic                           frame_done
);
  localparam int CW = cnt_width(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV-1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS-1);

  state_e                         state_q, state_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [NIBBLE_W*NUM_DIGITS-1:0] act_q, act_d, pend_q, pend_d;
  logic                           pflag_q, pflag_d;
  logic [NUM_DIGITS-1:0]          an_n_q, an_n_d, blank;
  logic [NIBBLE_W-1:0]            code_q, code_d;
  logic                           ack_q, ack_d, fd_q, fd_d;
  logic                           wrap, apply;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wrap    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (state_q == IDLE) begin
      state_d = DEAD;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (idx_q == IDX_LAST) begin
          idx_d = '0;
          wrap  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      state_d = (cnt_d < CNT_DEAD) ? DEAD : DRIVE;
    end
  end

  // A load on the apply edge itself wins over anything already pending.
  assign apply = (state_q == IDLE) || wrap;

  always_comb begin
    act_d   = act_q;
    pend_d  = pend_q;
    pflag_d = pflag_q;
    ack_d   = 1'b0;
    if (apply) begin
      if (load) begin
        act_d   = digits_in;
        pflag_d = 1'b0;
        ack_d   = 1'b1;
      end else if (pflag_q) begin
        act_d   = pend_q;
        pflag_d = 1'b0;
        ack_d   = 1'b1;
      end
    end else if (load) begin
      pend_d  = digits_in;
      pflag_d = 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_mask;
  seven_seg_lzb #(.NUM_DIGITS(NUM_DIGITS)) u_lzb (.digits(act_d), .mask(lz_mask));
  assign blank = blank_mask | lz_mask;
`else
  assign blank = blank_mask;
`endif

  // Outputs are computed from next-state values so they register in step with the state.
  always_comb begin
    an_n_d = '1;
    code_d = '0;
    fd_d   = wrap;
    if (state_d != IDLE) code_d = act_d[idx_d*NIBBLE_W +: NIBBLE_W];
    if (state_d == DRIVE && !blank[idx_d]) an_n_d[idx_d] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      act_q   <= '0;
      pend_q  <= '0;
      pflag_q <= 1'b0;
      an_n_q  <= '1;
      code_q  <= '0;
      ack_q   <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
      an_n_q  <= an_n_d;
      code_q  <= code_d;
      ack_q   <= ack_d;
      fd_q    <= fd_d;
    end
  end

  assign an_n       = an_n_q;
  assign digit_code = code_q;
  assign load_ack   = ack_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench: each test pushes the expected per-cycle outputs, a negedge monitor pops and compares.
module tb_seven_seg_scanner;
  localparam int N = 4;
  localparam int R = 8;
  localparam int D = 2;

  logic          clk, rst_n, enable, load;
  logic [4*N-1:0] digits_in;
  logic [N-1:0]  blank_mask, an_n;
  logic [3:0]    digit_code;
  logic          load_ack, frame_done;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] code;
    logic       ack;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 0;

  seven_seg_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .digits_in(digits_in),
    .blank_mask(blank_mask), .digit_code(digit_code), .an_n(an_n),
    .load_ack(load_ack), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow t=%0t got an=%b code=%h ack=%b fd=%b, nothing expected",
                 $time, an_n, digit_code, load_ack, frame_done);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if ({an_n, digit_code, load_ack, frame_done} !== e) begin
          errors++;
          $display("FAIL scan t=%0t got an=%b code=%h ack=%b fd=%b, expected an=%b code=%h ack=%b fd=%b",
                   $time, an_n, digit_code, load_ack, frame_done, e.an, e.code, e.ack, e.fd);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected outputs for one frame (or its first n_ent cycles) showing data d with blank mask m.
  task automatic push_frame(input logic [15:0] d, input logic [3:0] m, input bit fd0,
                            input bit ack0, input int n_ent);
    int k;
    exp_t e;
    k = 0;
    for (int i = 0; i < N; i++) begin
      for (int c = 0; c < R; c++) begin
        e.an   = (c < D || m[i]) ? 4'hF : ~(4'b0001 << i);
        e.code = d[i*4 +: 4];
        e.ack  = (k == 0) ? ack0 : 1'b0;
        e.fd   = (k == 0) ? fd0 : 1'b0;
        if (k < n_ent) sb.push_back(e);
        k++;
      end
    end
  endtask

  task automatic push_idle(input bit ack);
    exp_t e;
    e.an   = 4'hF;
    e.code = 4'h0;
    e.ack  = ack;
    e.fd   = 1'b0;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; digits_in = '0; blank_mask = '0;
    cyc(2);
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL reset_an got=%b exp=1111", an_n); end
    checks++; if (digit_code !== 4'h0) begin errors++; $display("FAIL reset_code got=%h exp=0", digit_code); end
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", load_ack); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
  endtask

  task automatic test_basic_scan;
    rst_n = 1'b1; enable = 1'b1; load = 1'b1; digits_in = 16'h4321;
    push_frame(16'h4321, 4'b0000, 1'b0, 1'b1, 32);
    cyc(1);
    load = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_frame_load;
    push_frame(16'h4321, 4'b0000, 1'b1, 1'b0, 32);
    push_frame(16'h9876, 4'b0000, 1'b1, 1'b1, 32);
    cyc(36);
    load = 1'b1; digits_in = 16'h9876;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic test_back_to_back;
    push_frame(16'h2222, 4'b0000, 1'b1, 1'b1, 32);
    push_frame(16'h3333, 4'b0000, 1'b1, 1'b1, 32);
    cyc(31);
    load = 1'b1; digits_in = 16'h1111;
    cyc(1);
    load = 1'b0;
    cyc(9);
    load = 1'b1; digits_in = 16'h2222;
    cyc(1);
    load = 1'b0;
    cyc(48);
    load = 1'b1; digits_in = 16'h3333;  // lands on the frame boundary edge
    cyc(1);
    load = 1'b0;
  endtask

  task automatic test_blank_mask;
    push_frame(16'h3333, 4'b0100, 1'b1, 1'b0, 32);
    cyc(31);
    blank_mask = 4'b0100;
    cyc(32);
    blank_mask = 4'b0000;
  endtask

  task automatic test_enable_drop;
    push_frame(16'h3333, 4'b0000, 1'b1, 1'b0, 12);
    push_idle(1'b0);
    push_idle(1'b0);
    push_idle(1'b1);
    push_idle(1'b0);
    push_idle(1'b0);
    push_frame(16'h5555, 4'b0000, 1'b0, 1'b0, 32);
    cyc(12);
    enable = 1'b0;
    cyc(1);
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL drop_an got=%b exp=1111", an_n); end
    cyc(1);
    load = 1'b1; digits_in = 16'h5555;
    cyc(1);
    load = 1'b0;
    checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL idle_ack got=%b exp=1", load_ack); end
    cyc(2);
    enable = 1'b1;
  endtask

  task automatic test_leading_zero;
    logic [3:0] ma, mb;
`ifdef LEADING_ZERO_BLANK_EN
    ma = 4'b1100;
    mb = 4'b1110;
`else
    ma = 4'b0000;
    mb = 4'b0000;
`endif
    push_frame(16'h0050, ma, 1'b1, 1'b1, 32);
    push_frame(16'h0000, mb, 1'b1, 1'b1, 32);
    cyc(10);
    load = 1'b1; digits_in = 16'h0050;
    cyc(1);
    load = 1'b0;
    cyc(39);
    load = 1'b1; digits_in = 16'h0000;
    cyc(1);
    load = 1'b0;
    cyc(46);
  endtask

  task automatic test_drain;
    mon_en = 1'b0;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got=%0d pending exp=0", sb.size()); end
  endtask

  task automatic test_async_reset;
    cyc(4);
    checks++; if (an_n !== 4'b1110) begin errors++; $display("FAIL pre_reset_an got=%b exp=1110", an_n); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL async_an got=%b exp=1111", an_n); end
    checks++; if (digit_code !== 4'h0) begin errors++; $display("FAIL async_code got=%h exp=0", digit_code); end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_frame_load();
    test_back_to_back();
    test_blank_mask();
    test_enable_drop();
    test_leading_zero();
    test_drain();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
